// File: rtl/if_stage.sv
// Instruction fetch: sequential PC, ROM req/gnt/rvalid, {pc,inst} buffer, IF/ID reg.
// Ports: clk, rst, stall_i, rom_* fetch bus, id_pc_o/id_inst_o/id_valid_o; macro IF_SKID_EN = 2-deep.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

`ifdef IF_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic [31:0] fetch_pc;
  logic [1:0]  outst;
  logic [1:0]  count;
  logic [31:0] h_pc;
  logic [31:0] h_inst;
`ifdef IF_SKID_EN
  logic [31:0] t_pc;
  logic [31:0] t_inst;
`endif

  logic        grant;
  logic        push;
  logic        pop;
  logic [2:0]  credit;
  logic [31:0] tag_pc;

  // Credits come from registered counters only.
  assign credit = {1'b0, outst} + {1'b0, count};
  assign rom_req_o = !rst && (credit < 3'(D));
  assign rom_addr_o = rst ? RESET_PC : fetch_pc;

  assign grant = rom_req_o && rom_gnt_i;
  // Stray responses with nothing in flight are dropped.
  assign push = rom_rvalid_i && (outst != 2'd0);
  assign pop = !stall_i && (count != 2'd0);

  // Oldest in-flight request sits outst words behind fetch_pc.
  assign tag_pc = fetch_pc - {28'd0, outst, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      outst      <= 2'd0;
      count      <= 2'd0;
      id_pc_o    <= 32'd0;
      id_inst_o  <= 32'd0;
      id_valid_o <= 1'b0;
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outst <= outst + {1'b0, grant} - {1'b0, push};
      count <= count + {1'b0, push} - {1'b0, pop};

      if (!stall_i) begin
        if (count != 2'd0) begin
          id_pc_o    <= h_pc;
          id_inst_o  <= h_inst;
          id_valid_o <= 1'b1;
        end else begin
          id_pc_o    <= 32'd0;
          id_inst_o  <= 32'd0;
          id_valid_o <= 1'b0;
        end
      end

`ifdef IF_SKID_EN
      if (pop) begin
        h_pc   <= t_pc;
        h_inst <= t_inst;
      end
      // New word lands at the first free slot after this pop.
      if (push) begin
        if (count == {1'b0, pop}) begin
          h_pc   <= tag_pc;
          h_inst <= rom_data_i;
        end else begin
          t_pc   <= tag_pc;
          t_inst <= rom_data_i;
        end
      end
`else
      if (push) begin
        h_pc   <= tag_pc;
        h_inst <= rom_data_i;
      end
`endif
    end
  end

endmodule
